// File: rtl/mac_vec_accumulator.sv
// Q4.4 x Q4.4 dot-product accumulator into a signed Q10.8 sum with valid/ready result port.
// Define ACC_SATURATE_EN to clamp the sum and report ovf; otherwise the sum wraps.
module mac_vec_accumulator #(
    parameter int IN_W    = 8,
    parameter int ACC_W   = 18,
    parameter int MAX_LEN = 64,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [IN_W-1:0]  in_b,
    input  logic             in_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    localparam int PROD_W = 2 * IN_W;
`ifdef ACC_SATURATE_EN
    localparam int NXT_W = ACC_W + 1;
`else
    localparam int NXT_W = ACC_W;
`endif

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   count;
    logic [PROD_W-1:0]  prod;
    logic [NXT_W-1:0]   nxt;
    logic [ACC_W-1:0]   nxt_fit;
    logic               beat;
    logic               done;
    logic               release_hs;

    assign beat       = in_valid & in_ready;
    assign release_hs = (state == HOLD) & acc_ready;
    assign done       = in_last | (count == CNT_W'(MAX_LEN - 1));
    assign prod       = PROD_W'($signed(in_a) * $signed(in_b));

    // Both operands sign-extended to the adder width before summing.
    assign nxt = {{(NXT_W - ACC_W){sum[ACC_W-1]}}, sum}
               + {{(NXT_W - PROD_W){prod[PROD_W-1]}}, prod};

`ifdef ACC_SATURATE_EN
    logic clamp;
    logic ovf_q;

    // Top two bits disagree exactly when the wide sum left the ACC_W range.
    assign clamp = nxt[ACC_W] ^ nxt[ACC_W-1];

    always_comb begin
        nxt_fit = nxt[ACC_W-1:0];
        if (clamp) begin
            nxt_fit = nxt[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (release_hs) begin
            ovf_q <= 1'b0;
        end else if (beat && clamp) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign nxt_fit = nxt;
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            sum       <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            acc_valid <= 1'b0;
            acc       <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (beat) begin
                        sum   <= nxt_fit;
                        acc   <= nxt_fit;
                        count <= count + 1'b1;
                        if (done) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // acc keeps the finished sum until the next beat lands.
                    if (acc_ready) begin
                        state     <= ACCUM;
                        sum       <= '0;
                        count     <= '0;
                        in_ready  <= 1'b1;
                        acc_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_vec_accumulator.sv
// Directed and random bench for mac_vec_accumulator against an integer dot-product model.
// Follows ACC_SATURATE_EN for the expected clamp/wrap behaviour.
module tb_mac_vec_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_last = 1'b0;
    logic        acc_valid;
    logic        acc_ready = 1'b0;
    logic [17:0] acc;
    logic        ovf;

    int n_checks = 0;
    int n_fails  = 0;
    int va [64];
    int vb [64];
    int vn;
    logic [17:0] exp_acc;
    logic        exp_ovf;

    mac_vec_accumulator #(
        .IN_W(8), .ACC_W(18), .MAX_LEN(64), .CNT_W(7)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc(acc), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dot product of the current vector in plain integers.
    task automatic model();
        int s;
        bit o;
        s = 0;
        o = 1'b0;
        for (int i = 0; i < vn; i++) begin
            s = s + va[i] * vb[i];
`ifdef ACC_SATURATE_EN
            if (s > 131071) begin
                s = 131071;
                o = 1'b1;
            end else if (s < -131072) begin
                s = -131072;
                o = 1'b1;
            end
`endif
        end
        exp_acc = s[17:0];
        exp_ovf = o;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int n, input int a, input int b);
        vn = n;
        for (int i = 0; i < n; i++) begin
            va[i] = a;
            vb[i] = b;
        end
    endtask

    task automatic feed(input bit use_last, input string tag);
        int guard;
        for (int i = 0; i < vn; i++) begin
            in_valid = 1'b1;
            in_a     = 8'(va[i]);
            in_b     = 8'(vb[i]);
            in_last  = use_last && (i == vn - 1);
            guard    = 0;
            while (!in_ready && guard < 50) begin
                cyc();
                guard++;
            end
            if (guard >= 50) check({tag, "_rdy_timeout"}, 32'(in_ready), 1);
            if (i == vn - 1) check({tag, "_early_valid"}, 32'(acc_valid), 0);
            cyc();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        model();
        check({tag, "_valid"}, 32'(acc_valid), 1);
        check({tag, "_rdy_hold"}, 32'(in_ready), 0);
        check({tag, "_acc"}, 32'(acc), 32'(exp_acc));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic release_hs(input string tag);
        acc_ready = 1'b1;
        cyc();
        acc_ready = 1'b0;
        check({tag, "_rel_valid"}, 32'(acc_valid), 0);
        check({tag, "_rel_rdy"}, 32'(in_ready), 1);
        check({tag, "_rel_ovf"}, 32'(ovf), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_acc_valid"}, 32'(acc_valid), 0);
        check({tag, "_acc"}, 32'(acc), 0);
        check({tag, "_ovf"}, 32'(ovf), 0);
    endtask

    initial begin
        int waitc;
        rst = 1'b1;
        cyc();
        cyc();
        check_reset("reset");
        rst = 1'b0;

        fill(3, 16, 16);
        feed(1'b1, "t1");
        check("t1_const", 32'(acc), 32'h00300);
        release_hs("t1");

        vn = 2;
        va[0] = -16; vb[0] = 32;
        va[1] = 8;   vb[1] = 16;
        feed(1'b1, "t2");
        check("t2_const", 32'(acc), 32'h3FE80);
        release_hs("t2");

        fill(9, 127, 127);
        feed(1'b1, "t3");
        release_hs("t3");

        fill(9, -128, 127);
        feed(1'b1, "t4");
        release_hs("t4");
        fill(1, 16, 16);
        feed(1'b1, "t4b");
        check("t4b_const", 32'(acc), 32'h00100);
        release_hs("t4b");

        fill(2, 37, -5);
        feed(1'b1, "t5");
        in_valid = 1'b1;
        in_a     = 8'h10;
        in_b     = 8'h30;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t5_stable", 32'(acc), 32'(exp_acc));
            check("t5_rdy", 32'(in_ready), 0);
        end
        acc_ready = 1'b1;
        cyc();
        acc_ready = 1'b0;
        check("t5_hs_rdy", 32'(in_ready), 1);
        check("t5_hs_valid", 32'(acc_valid), 0);
        fill(1, 16, 48);
        feed(1'b1, "t5b");
        release_hs("t5b");

        fill(64, 16, 16);
        feed(1'b0, "t6");
        check("t6_const", 32'(acc), 32'h04000);
        release_hs("t6");
        in_valid = 1'b1;
        in_a     = 8'h10;
        in_b     = 8'h10;
        for (int k = 0; k < 9; k++) cyc();
        rst = 1'b1;
        cyc();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset("t6_rst");
        fill(3, -20, 9);
        feed(1'b1, "t6b");
        release_hs("t6b");

        for (int r = 0; r < 20; r++) begin
            vn = int'($urandom_range(1, 20));
            for (int i = 0; i < vn; i++) begin
                va[i] = int'($urandom_range(0, 255)) - 128;
                vb[i] = int'($urandom_range(0, 255)) - 128;
            end
            feed(1'b1, "rnd");
            waitc = int'($urandom_range(0, 3));
            for (int k = 0; k < waitc; k++) begin
                cyc();
                check("rnd_hold", 32'(acc), 32'(exp_acc));
            end
            release_hs("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
